// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: definitions shared by the hazard detection unit and the
// pipeline register controller.
//   haz_state_t - hazard FSM states; the encoding doubles as the hazType code
//   HAZ_*       - hazType codes seen by the pipeline register controller
//   REG_W       - register specifier width; REG_ZERO is the hardwired $0
package mips_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam logic [1:0] HAZ_NONE    = 2'b00;  // no hazard
  localparam logic [1:0] HAZ_LOADUSE = 2'b01;  // stall PC and IF_ID, bubble into EX
  localparam logic [1:0] HAZ_FLUSH   = 2'b10;  // branch/jump flush
  localparam logic [1:0] HAZ_MEMWAIT = 2'b11;  // stall all stages, no bubble

  typedef enum logic [1:0] {
    ST_RUN     = HAZ_NONE,
    ST_LDUSE   = HAZ_LOADUSE,
    ST_FLUSH   = HAZ_FLUSH,
    ST_MEMWAIT = HAZ_MEMWAIT
  } haz_state_t;

  function automatic logic [1:0] haz_code(haz_state_t s);
    return logic'(s[1]) ? {1'b1, s[0]} : {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use comparator.
// Ports:
//   i_if_id_rs, i_if_id_rt : source registers of the instruction in ID
//   i_id_ex_rt             : destination register of the instruction in EX
//   i_id_ex_memread        : instruction in EX is a load
//   o_load_use             : ID reads the register the EX load will write
//                            ($0 never creates a dependency)
module hazard_cmp
  import mips_pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_if_id_rs,
  input  logic [REG_W-1:0] i_if_id_rt,
  input  logic [REG_W-1:0] i_id_ex_rt,
  input  logic             i_id_ex_memread,
  output logic             o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  always_comb begin
    w_rs_match = (i_id_ex_rt == i_if_id_rs);
    w_rt_match = (i_id_ex_rt == i_if_id_rt);
    o_load_use = i_id_ex_memread && (i_id_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: pipeline hazard FSM producing a registered hazard code.
// Parameters:
//   FLUSH_CYCLES : cycles the branch/jump flush state is held (1..3)
//   CNT_W        : width of the optional performance counters
// Ports:
//   Clk, Rst_n           : clock, synchronous active-low reset
//   IF_ID_Rs, IF_ID_Rt   : source registers of the instruction in ID
//   ID_EX_Rt             : destination register of the instruction in EX
//   ID_EX_MemRead        : instruction in EX is a load
//   BranchTaken, Jump    : branch resolved taken in EX / jump decoded in ID
//   EX_MEM_MemAcc        : load/store occupying MEM
//   MemReady             : data memory completes the access this cycle
//   hazType              : 00 none, 01 load-use, 10 flush, 11 memory wait
//   hazBusy              : hazType != 00
// Optional build macro HAZ_PERF_CNT_EN adds stallCnt (cycles in load-use or
// memory wait) and flushCnt (cycles in flush), both saturating at all-ones.
module hazard_detect_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic             ID_EX_MemRead,
  input  logic             BranchTaken,
  input  logic             Jump,
  input  logic             EX_MEM_MemAcc,
  input  logic             MemReady,
  output logic [1:0]       hazType,
  output logic             hazBusy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
`endif
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
    $error("hazard_detect_unit: FLUSH_CYCLES must be 1..3");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_detect_unit: CNT_W must be at least 1");
  end

  localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES);

  haz_state_t r_state;
  haz_state_t w_next;
  logic [1:0] r_flush_cnt;
  logic       r_branch_pend;
  logic       w_load_use;
  logic       w_branch;
  logic       w_mem_stall;
  logic       w_reload;

  hazard_cmp u_cmp (
    .i_if_id_rs      (IF_ID_Rs),
    .i_if_id_rt      (IF_ID_Rt),
    .i_id_ex_rt      (ID_EX_Rt),
    .i_id_ex_memread (ID_EX_MemRead),
    .o_load_use      (w_load_use)
  );

  always_comb begin
    w_branch    = BranchTaken | Jump;
    w_mem_stall = EX_MEM_MemAcc & ~MemReady;
    w_next      = ST_RUN;
    case (r_state)
      ST_MEMWAIT: begin
        // Only MemReady ends the wait; a branch seen now or earlier flushes next.
        if (!MemReady)                       w_next = ST_MEMWAIT;
        else if (r_branch_pend || w_branch)  w_next = ST_FLUSH;
        else                                 w_next = ST_RUN;
      end
      ST_LDUSE: begin
        // loadUse masked: the pair that caused this stall must not re-trigger it.
        if (w_mem_stall)   w_next = ST_MEMWAIT;
        else if (w_branch) w_next = ST_FLUSH;
        else               w_next = ST_RUN;
      end
      ST_FLUSH: begin
        if (w_mem_stall)             w_next = ST_MEMWAIT;
        else if (w_branch)           w_next = ST_FLUSH;
        else if (r_flush_cnt > 2'd1) w_next = ST_FLUSH;
        else if (w_load_use)         w_next = ST_LDUSE;
        else                         w_next = ST_RUN;
      end
      default: begin
        if (w_mem_stall)     w_next = ST_MEMWAIT;
        else if (w_branch)   w_next = ST_FLUSH;
        else if (w_load_use) w_next = ST_LDUSE;
        else                 w_next = ST_RUN;
      end
    endcase
    // Counter reloads on flush entry and on any new branch/jump while flushing.
    w_reload = (w_next == ST_FLUSH) && ((r_state != ST_FLUSH) || w_branch);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state       <= ST_RUN;
      r_flush_cnt   <= '0;
      r_branch_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_FLUSH) begin
        r_flush_cnt <= w_reload ? FC_LOAD : (r_flush_cnt - 2'd1);
      end
      if (w_next == ST_FLUSH) begin
        r_branch_pend <= 1'b0;
      end else if (r_state == ST_MEMWAIT && w_branch) begin
        r_branch_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    hazType = haz_code(r_state);
    hazBusy = (r_state != ST_RUN);
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_perf;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_stall_cnt  <= '0;
      r_flush_perf <= '0;
    end else begin
      if ((r_state == ST_LDUSE || r_state == ST_MEMWAIT) && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (r_state == ST_FLUSH && r_flush_perf != '1) begin
        r_flush_perf <= r_flush_perf + 1'b1;
      end
    end
  end

  assign stallCnt = r_stall_cnt;
  assign flushCnt = r_flush_perf;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit. Two instances share all inputs:
// u_dut1 with FLUSH_CYCLES=1, CNT_W=4 and u_dut2 with FLUSH_CYCLES=2, CNT_W=16.
// Directed scenarios check fixed expected codes; the random phase checks
// against a reference model kept in terms of hazard codes and flush cycles served.
module tb_hazard_detect_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       mr, bt, jmp, macc, mrdy;
  logic [1:0] haz1, haz2;
  logic       busy1, busy2;
`ifdef HAZ_PERF_CNT_EN
  logic [3:0]  stall1, flush1;
  logic [15:0] stall2, flush2;
`endif

  hazard_detect_unit #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_EX_Rt(ex_rt),
    .ID_EX_MemRead(mr), .BranchTaken(bt), .Jump(jmp), .EX_MEM_MemAcc(macc),
    .MemReady(mrdy), .hazType(haz1), .hazBusy(busy1)
`ifdef HAZ_PERF_CNT_EN
    , .stallCnt(stall1), .flushCnt(flush1)
`endif
  );

  hazard_detect_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_EX_Rt(ex_rt),
    .ID_EX_MemRead(mr), .BranchTaken(bt), .Jump(jmp), .EX_MEM_MemAcc(macc),
    .MemReady(mrdy), .hazType(haz2), .hazBusy(busy2)
`ifdef HAZ_PERF_CNT_EN
    , .stallCnt(stall2), .flushCnt(flush2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 -> u_dut1, 1 -> u_dut2.
  int m_code[2], m_served[2], m_pend[2], m_stall[2], m_flush[2];
  int fc[2]   = '{1, 2};
  int cmax[2] = '{15, 65535};

  function automatic logic [1:0] dut_haz(int k);
    return (k == 0) ? haz1 : haz2;
  endfunction

  function automatic logic dut_busy(int k);
    return (k == 0) ? busy1 : busy2;
  endfunction

`ifdef HAZ_PERF_CNT_EN
  function automatic int dut_stall(int k);
    return (k == 0) ? int'(stall1) : int'(stall2);
  endfunction
  function automatic int dut_flush(int k);
    return (k == 0) ? int'(flush1) : int'(flush2);
  endfunction
`endif

  function automatic void model_step(int k);
    int  c, nc;
    bit  lu, br, stall;
    if (!Rst_n) begin
      m_code[k] = 0; m_served[k] = 0; m_pend[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      return;
    end
    c     = m_code[k];
    lu    = mr && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    br    = bt || jmp;
    stall = macc && !mrdy;
    if ((c == 1 || c == 3) && m_stall[k] < cmax[k]) m_stall[k]++;
    if (c == 2 && m_flush[k] < cmax[k]) m_flush[k]++;
    if (c == 3)                              nc = !mrdy ? 3 : ((m_pend[k] != 0 || br) ? 2 : 0);
    else if (stall)                          nc = 3;
    else if (br)                             nc = 2;
    else if (c == 2 && m_served[k] < fc[k])  nc = 2;
    else if (lu && c != 1)                   nc = 1;
    else                                     nc = 0;
    if (nc == 2) m_served[k] = (c == 2 && !br) ? m_served[k] + 1 : 1;
    if (nc == 2) m_pend[k] = 0;
    else if (c == 3 && br) m_pend[k] = 1;
    m_code[k] = nc;
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic set_in(input logic r, input logic [4:0] i_rs, input logic [4:0] i_rt,
                        input logic [4:0] i_ex, input logic i_mr, input logic i_bt,
                        input logic i_j, input logic i_macc, input logic i_mrdy);
    Rst_n = r; rs = i_rs; rt = i_rt; ex_rt = i_ex; mr = i_mr;
    bt = i_bt; jmp = i_j; macc = i_macc; mrdy = i_mrdy;
  endtask

  task automatic test_reset();
    set_in(1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dut_haz(k) !== 2'b00) begin
        n_err++; $display("FAIL reset_haz dut%0d: got %b expected 00", k, dut_haz(k));
      end
      n_cmp++;
      if (dut_busy(k) !== 1'b0) begin
        n_err++; $display("FAIL reset_busy dut%0d: got %b expected 0", k, dut_busy(k));
      end
`ifdef HAZ_PERF_CNT_EN
      n_cmp++;
      if (dut_stall(k) != 0 || dut_flush(k) != 0) begin
        n_err++; $display("FAIL reset_cnt dut%0d: stall %0d flush %0d expected 0 0", k, dut_stall(k), dut_flush(k));
      end
`endif
    end
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_load_use();
    logic [1:0] exp[3] = '{2'b01, 2'b00, 2'b00};
    set_in(1'b1, 5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (dut_haz(k) !== exp[s]) begin
          n_err++; $display("FAIL load_use step%0d dut%0d: got %b expected %b", s, k, dut_haz(k), exp[s]);
        end
      end
      if (s == 1) set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_rt_zero();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (dut_haz(k) !== 2'b00) begin
          n_err++; $display("FAIL rt_zero step%0d dut%0d: got %b expected 00", s, k, dut_haz(k));
        end
      end
    end
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch_flush();
    // rows: step; columns: dut1 (1 flush cycle), dut2 (2 flush cycles)
    logic [1:0] exp[3][2] = '{'{2'b10, 2'b10}, '{2'b00, 2'b10}, '{2'b00, 2'b00}};
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      bt = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (dut_haz(k) !== exp[s][k]) begin
          n_err++; $display("FAIL branch_flush step%0d dut%0d: got %b expected %b", s, k, dut_haz(k), exp[s][k]);
        end
      end
    end
  endtask

  task automatic test_memwait_jump();
    logic [1:0] exp[6][2] = '{'{2'b11, 2'b11}, '{2'b11, 2'b11}, '{2'b11, 2'b11},
                              '{2'b10, 2'b10}, '{2'b00, 2'b10}, '{2'b00, 2'b00}};
    for (int s = 0; s < 6; s++) begin
      case (s)
        0, 2:    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        1:       set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        3:       set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        default: set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (dut_haz(k) !== exp[s][k]) begin
          n_err++; $display("FAIL memwait_jump step%0d dut%0d: got %b expected %b", s, k, dut_haz(k), exp[s][k]);
        end
      end
    end
  endtask

  task automatic test_priority();
    set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (dut_haz(k) !== 2'b11) begin
          n_err++; $display("FAIL priority step%0d dut%0d: got %b expected 11", s, k, dut_haz(k));
        end
      end
    end
    // Branch was held during the wait, so release goes to flush.
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dut_haz(k) !== 2'b10) begin
        n_err++; $display("FAIL priority_release dut%0d: got %b expected 10", k, dut_haz(k));
      end
    end
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dut_haz(k) !== 2'b00) begin
        n_err++; $display("FAIL priority_idle dut%0d: got %b expected 00", k, dut_haz(k));
      end
    end
  endtask

  task automatic test_reset_mid_memwait();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dut_haz(k) !== 2'b11) begin
        n_err++; $display("FAIL pre_reset_memwait dut%0d: got %b expected 11", k, dut_haz(k));
      end
    end
    Rst_n = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dut_haz(k) !== 2'b00 || dut_busy(k) !== 1'b0) begin
        n_err++; $display("FAIL reset_memwait dut%0d: haz %b busy %b expected 00 0", k, dut_haz(k), dut_busy(k));
      end
`ifdef HAZ_PERF_CNT_EN
      n_cmp++;
      if (dut_stall(k) != 0) begin
        n_err++; $display("FAIL reset_memwait_cnt dut%0d: stallCnt %0d expected 0", k, dut_stall(k));
      end
`endif
    end
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      set_in(($urandom_range(0, 59) != 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) != 0));
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (dut_haz(k) !== 2'(m_code[k]) || dut_busy(k) !== (m_code[k] != 0)) begin
          n_err++;
          $display("FAIL random cyc%0d dut%0d: haz %b busy %b expected %b %b", n, k,
                   dut_haz(k), dut_busy(k), 2'(m_code[k]), (m_code[k] != 0));
        end
`ifdef HAZ_PERF_CNT_EN
        n_cmp++;
        if (dut_stall(k) != m_stall[k] || dut_flush(k) != m_flush[k]) begin
          n_err++;
          $display("FAIL random_cnt cyc%0d dut%0d: stall %0d flush %0d expected %0d %0d", n, k,
                   dut_stall(k), dut_flush(k), m_stall[k], m_flush[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_zero();
    test_branch_flush();
    test_memwait_jump();
    test_priority();
    test_reset_mid_memwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
